// File: rtl/omsp_spm_cmd_seq_if.sv
// Command/response channel between the execution unit (master) and the
// SPM command sequencer (slave).
interface omsp_spm_cmd_seq_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_r12;
   logic [15:0] cmd_r13;
   logic [15:0] cmd_r14;
   logic [15:0] cmd_r15;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_error;
   logic [63:0] rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_r12, cmd_r13, cmd_r14, cmd_r15, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_error, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_r12, cmd_r13, cmd_r14, cmd_r15, rsp_ready,
      output cmd_ready, rsp_valid, rsp_error, rsp_data
   );
endinterface

// File: rtl/omsp_spm_cmd_seq.sv
// SPM command sequencer: issues protect/unprotect strobes or walks the four
// layout words of the selected SPM, then returns status/data on a handshake.
module omsp_spm_cmd_seq #(
   parameter int READ_WAIT = 1
) (
   input  logic                 mclk,
   input  logic                 puc_rst,
   omsp_spm_cmd_seq_if.slave    cmd_if,
   output logic                 update_spm,
   output logic                 enable_spm,
   output logic [15:0]          r12,
   output logic [15:0]          r13,
   output logic [15:0]          r14,
   output logic [15:0]          r15,
   output logic [1:0]           data_request,
   input  logic                 violation,
   input  logic                 spm_select_valid,
   input  logic [15:0]          requested_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 1);

   state_t      state;
   logic [1:0]  idx;
   logic [3:0]  wait_cnt;
   logic        cmd_ready;
   logic        rsp_valid;
   logic        rsp_error;
   logic [63:0] rsp_data;

   assign cmd_if.cmd_ready = cmd_ready;
   assign cmd_if.rsp_valid = rsp_valid;
   assign cmd_if.rsp_error = rsp_error;
   assign cmd_if.rsp_data  = rsp_data;

   // Every output is a register updated on the transition that enters or
   // leaves the state it belongs to, so nothing toward the SPM controller glitches.
   always_ff @(posedge mclk) begin
      if (!puc_rst) begin
         state        <= IDLE;
         idx          <= 2'd0;
         wait_cnt     <= 4'd0;
         cmd_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_error    <= 1'b0;
         rsp_data     <= 64'd0;
         update_spm   <= 1'b0;
         enable_spm   <= 1'b0;
         r12          <= 16'd0;
         r13          <= 16'd0;
         r14          <= 16'd0;
         r15          <= 16'd0;
         data_request <= 2'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_if.cmd_valid) begin
                  r12       <= cmd_if.cmd_r12;
                  r13       <= cmd_if.cmd_r13;
                  r14       <= cmd_if.cmd_r14;
                  r15       <= cmd_if.cmd_r15;
                  rsp_error <= 1'b0;
                  rsp_data  <= 64'd0;
                  cmd_ready <= 1'b0;
                  unique case (cmd_if.cmd_op)
                     2'b00, 2'b01: begin
                        state      <= ISSUE;
                        update_spm <= 1'b1;
                        enable_spm <= (cmd_if.cmd_op == 2'b00);
                     end
                     2'b10: begin
                        state        <= READ;
                        idx          <= 2'd0;
                        wait_cnt     <= 4'd0;
                        data_request <= 2'd0;
                     end
                     default: begin
                        state     <= RESP;
                        rsp_error <= 1'b1;
                        rsp_valid <= 1'b1;
                     end
                  endcase
               end
            end

            ISSUE: begin
               update_spm <= 1'b0;
               enable_spm <= 1'b0;
               rsp_error  <= violation;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end

            READ: begin
               if (wait_cnt == WAIT_LAST) begin
                  if (spm_select_valid) begin
                     rsp_data[{idx, 4'd0} +: 16] <= requested_data;
                     if (idx == 2'd3) begin
                        state        <= RESP;
                        rsp_valid    <= 1'b1;
                        data_request <= 2'd0;
                     end else begin
                        idx          <= idx + 2'd1;
                        wait_cnt     <= 4'd0;
                        data_request <= idx + 2'd1;
                     end
                  end else begin
                     // Selection lost mid-walk: keep the words gathered so far.
                     rsp_error    <= 1'b1;
                     rsp_valid    <= 1'b1;
                     data_request <= 2'd0;
                     state        <= RESP;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end

            RESP: begin
               if (cmd_if.rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
